// File: rtl/gemm_pkg.sv
// Shared types for the GeMM tile sequencer: FSM states, B layout selector and the
// per-beat tag that travels alongside SRAM read data.
package gemm_pkg;

    localparam int unsigned GemmSizeWidth = 8;
    localparam int unsigned GemmAddrWidth = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gemm_state_e;

    typedef enum logic {
        B_NK = 1'b0,
        B_KN = 1'b1
    } b_layout_e;

    typedef struct packed {
        logic                     first;
        logic                     last;
        logic [GemmAddrWidth-1:0] c_addr;
    } beat_tag_t;

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Host job registers plus SRAM / MAC-array control bundle of the tile sequencer.
interface gemm_tile_sequencer_if #(
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned AddrWidth     = 16
) ();

    logic                     start_i;
    logic                     abort_i;
    logic                     stall_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic [AddrWidth-1:0]     a_base_i;
    logic [AddrWidth-1:0]     b_base_i;
    logic [AddrWidth-1:0]     c_base_i;
    logic                     b_layout_i;

    logic                     sram_rd_en_o;
    logic [AddrWidth-1:0]     sram_a_addr_o;
    logic [AddrWidth-1:0]     sram_b_addr_o;
    logic                     mac_valid_o;
    logic                     mac_init_save_o;
    logic                     mac_acc_clr_o;
    logic                     sram_c_we_o;
    logic [AddrWidth-1:0]     sram_c_addr_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, abort_i, stall_i, M_size_i, K_size_i, N_size_i,
               a_base_i, b_base_i, c_base_i, b_layout_i,
        input  sram_rd_en_o, sram_a_addr_o, sram_b_addr_o, mac_valid_o,
               mac_init_save_o, mac_acc_clr_o, sram_c_we_o, sram_c_addr_o,
               busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, stall_i, M_size_i, K_size_i, N_size_i,
               a_base_i, b_base_i, c_base_i, b_layout_i,
        output sram_rd_en_o, sram_a_addr_o, sram_b_addr_o, mac_valid_o,
               mac_init_save_o, mac_acc_clr_o, sram_c_we_o, sram_c_addr_o,
               busy_o, done_o
    );

endinterface

// File: rtl/gemm_tag_delay.sv
// Depth-stage shift register carrying valid + beat tag so MAC control lines up with
// SRAM read data; flush clears every stage on the next edge.
module gemm_tag_delay
    import gemm_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      valid_i,
    input  beat_tag_t tag_i,
    output logic      valid_o,
    output beat_tag_t tag_o,
    output logic      busy_o
);

    logic [Depth-1:0] valid_q;
    beat_tag_t        tag_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Depth); i++) tag_q[i] <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Depth); i++) tag_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int i = 1; i < int'(Depth); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign tag_o   = tag_q[Depth-1];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks the (m, n, k) block loops of a GeMM job, issuing A/B SRAM reads, aligned MAC
// control and C write-backs, with stall, abort and zero-size job handling.
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int unsigned SizeAddrWidth = GemmSizeWidth,
    parameter int unsigned AddrWidth     = GemmAddrWidth,
    parameter int unsigned ReadLatency   = 1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    gemm_tile_sequencer_if.slave bus
);

    gemm_state_e              state_q, state_d;
    logic [SizeAddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic [SizeAddrWidth-1:0] m_size_q, m_size_d, n_size_q, n_size_d, k_size_q, k_size_d;
    logic [AddrWidth-1:0]     a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    b_layout_e                b_layout_q, b_layout_d;

    logic                     c_we_q, c_we_d;
    logic [AddrWidth-1:0]     c_addr_q, c_addr_d;
    logic                     busy_q, busy_d, done_q, done_d, acc_clr_q, acc_clr_d;

    logic                     issue_c, flush_c, size_zero_c;
    logic                     last_k_c, last_n_c, last_m_c;
    logic [AddrWidth-1:0]     a_addr_c, b_addr_c, c_addr_c;
    beat_tag_t                issue_tag_c, dly_tag;
    logic                     dly_valid, pipe_busy;

    assign issue_c     = (state_q == ST_RUN) && !bus.stall_i && !bus.abort_i;
    assign flush_c     = bus.abort_i && (state_q != ST_IDLE);
    assign size_zero_c = (bus.M_size_i == '0) || (bus.K_size_i == '0) || (bus.N_size_i == '0);
    assign last_k_c    = (k_q == k_size_q - SizeAddrWidth'(1));
    assign last_n_c    = (n_q == n_size_q - SizeAddrWidth'(1));
    assign last_m_c    = (m_q == m_size_q - SizeAddrWidth'(1));

    // Block addresses from the live counters; all sums wrap at AddrWidth.
    always_comb begin
        a_addr_c = a_base_q + AddrWidth'(m_q) * AddrWidth'(k_size_q) + AddrWidth'(k_q);
        if (b_layout_q == B_NK) begin
            b_addr_c = b_base_q + AddrWidth'(n_q) * AddrWidth'(k_size_q) + AddrWidth'(k_q);
        end else begin
            b_addr_c = b_base_q + AddrWidth'(k_q) * AddrWidth'(n_size_q) + AddrWidth'(n_q);
        end
        c_addr_c = c_base_q + AddrWidth'(m_q) * AddrWidth'(n_size_q) + AddrWidth'(n_q);
    end

    // first/last are pre-qualified by issue so the delayed tag bits drive outputs directly.
    always_comb begin
        issue_tag_c        = '0;
        issue_tag_c.first  = issue_c && (k_q == '0);
        issue_tag_c.last   = issue_c && last_k_c;
        issue_tag_c.c_addr = GemmAddrWidth'(c_addr_c);
    end

    gemm_tag_delay #(
        .Depth (ReadLatency)
    ) u_tag_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_c),
        .valid_i (issue_c),
        .tag_i   (issue_tag_c),
        .valid_o (dly_valid),
        .tag_o   (dly_tag),
        .busy_o  (pipe_busy)
    );

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        k_d        = k_q;
        m_size_d   = m_size_q;
        n_size_d   = n_size_q;
        k_size_d   = k_size_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        c_base_d   = c_base_q;
        b_layout_d = b_layout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    m_size_d   = bus.M_size_i;
                    n_size_d   = bus.N_size_i;
                    k_size_d   = bus.K_size_i;
                    a_base_d   = bus.a_base_i;
                    b_base_d   = bus.b_base_i;
                    c_base_d   = bus.c_base_i;
                    b_layout_d = b_layout_e'(bus.b_layout_i);
                    m_d        = '0;
                    n_d        = '0;
                    k_d        = '0;
                    state_d    = size_zero_c ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (issue_c) begin
                    if (last_k_c) begin
                        k_d = '0;
                        if (last_n_c) begin
                            n_d = '0;
                            m_d = m_q + SizeAddrWidth'(1);
                        end else begin
                            n_d = n_q + SizeAddrWidth'(1);
                        end
                    end else begin
                        k_d = k_q + SizeAddrWidth'(1);
                    end
                    if (last_k_c && last_n_c && last_m_c) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final write is on the bus once the pipe is empty and we is up.
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (!pipe_busy && c_we_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        c_we_d    = dly_valid && dly_tag.last && !bus.abort_i;
        c_addr_d  = c_we_d ? AddrWidth'(dly_tag.c_addr) : c_addr_q;
        busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        acc_clr_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            m_size_q   <= '0;
            n_size_q   <= '0;
            k_size_q   <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
            b_layout_q <= B_NK;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            k_q        <= k_d;
            m_size_q   <= m_size_d;
            n_size_q   <= n_size_d;
            k_size_q   <= k_size_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            c_base_q   <= c_base_d;
            b_layout_q <= b_layout_d;
            c_we_q     <= c_we_d;
            c_addr_q   <= c_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_clr_q  <= acc_clr_d;
        end
    end

    assign bus.sram_rd_en_o    = issue_c;
    assign bus.sram_a_addr_o   = issue_c ? a_addr_c : '0;
    assign bus.sram_b_addr_o   = issue_c ? b_addr_c : '0;
    assign bus.mac_valid_o     = dly_valid;
    assign bus.mac_init_save_o = dly_tag.first;
    assign bus.mac_acc_clr_o   = acc_clr_q;
    assign bus.sram_c_we_o     = c_we_q;
    assign bus.sram_c_addr_o   = c_addr_q;
    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer: two instances (ReadLatency 1 and 3) share stimulus and are
// compared cycle by cycle against a loop-level timeline model of each job.
module tb_gemm_tile_sequencer;

    localparam int MaxCyc = 512;
    typedef logic [54:0] snap_t;  // {rd,a[16],b[16],mv,init,we,caddr[16],done,busy,acc}

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gemm_tile_sequencer_if #(.SizeAddrWidth(8), .AddrWidth(16)) if1 ();
    gemm_tile_sequencer_if #(.SizeAddrWidth(8), .AddrWidth(16)) if3 ();

    gemm_tile_sequencer #(.ReadLatency(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    gemm_tile_sequencer #(.ReadLatency(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_of [2] = '{1, 3};
    int          j_m, j_k, j_n, j_ab;
    logic [15:0] j_abase, j_bbase, j_cbase;
    logic        j_lay;
    logic        stall_mask [MaxCyc];
    snap_t       exp_s [2][MaxCyc];
    snap_t       obs_s [2][MaxCyc];
    int          t_end [2];
    int          n_cyc;

    function automatic snap_t pack(input logic rd, input logic [15:0] a, input logic [15:0] b,
                                   input logic mv, input logic init, input logic we,
                                   input logic [15:0] ca, input logic done, input logic busy,
                                   input logic acc);
        return {rd, a, b, mv, init, we, ca, done, busy, acc};
    endfunction

    task automatic set_job(input int m, input int k, input int n, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c, input logic lay,
                           input int ab);
        j_m = m; j_k = k; j_n = n; j_abase = a; j_bbase = b; j_cbase = c; j_lay = lay; j_ab = ab;
        for (int i = 0; i < MaxCyc; i++) stall_mask[i] = 1'b0;
    endtask

    task automatic drive(input logic start, input logic stall, input logic abort);
        if1.start_i = start;   if3.start_i = start;
        if1.stall_i = stall;   if3.stall_i = stall;
        if1.abort_i = abort;   if3.abort_i = abort;
        if1.M_size_i = 8'(j_m); if3.M_size_i = 8'(j_m);
        if1.K_size_i = 8'(j_k); if3.K_size_i = 8'(j_k);
        if1.N_size_i = 8'(j_n); if3.N_size_i = 8'(j_n);
        if1.a_base_i = j_abase; if3.a_base_i = j_abase;
        if1.b_base_i = j_bbase; if3.b_base_i = j_bbase;
        if1.c_base_i = j_cbase; if3.c_base_i = j_cbase;
        if1.b_layout_i = j_lay; if3.b_layout_i = j_lay;
    endtask

    // Timeline from the job description: beats in m/n/k order, one per unstalled cycle.
    task automatic build_model(input int li);
        int L, t, ab, last_t, hi;
        bit stop;
        logic rd [MaxCyc], mv [MaxCyc], init [MaxCyc], we [MaxCyc], dn [MaxCyc], bz [MaxCyc];
        logic [15:0] ea [MaxCyc], eb [MaxCyc], ec [MaxCyc];
        L  = lat_of[li];
        ab = (j_ab < 0) ? 4 * MaxCyc : j_ab;
        for (int c = 0; c < MaxCyc; c++) begin
            rd[c] = 0; mv[c] = 0; init[c] = 0; we[c] = 0; dn[c] = 0; bz[c] = 0;
            ea[c] = '0; eb[c] = '0; ec[c] = '0;
        end
        if (j_m == 0 || j_k == 0 || j_n == 0) begin
            dn[1] = 1;
            t_end[li] = 3;
        end else begin
            t = 1; stop = 0; last_t = 0;
            for (int m = 0; m < j_m; m++)
                for (int n = 0; n < j_n; n++)
                    for (int k = 0; k < j_k; k++) begin
                        if (!stop) begin
                            while (t < ab && t < MaxCyc - 16 && stall_mask[t]) t++;
                            if (t >= ab) begin
                                stop = 1;
                            end else begin
                                rd[t] = 1;
                                ea[t] = 16'(int'(j_abase) + m * j_k + k);
                                eb[t] = j_lay ? 16'(int'(j_bbase) + k * j_n + n)
                                              : 16'(int'(j_bbase) + n * j_k + k);
                                if (t + L <= ab) begin
                                    mv[t+L] = 1;
                                    init[t+L] = (k == 0);
                                end
                                if (k == j_k - 1 && t + L + 1 <= ab) begin
                                    we[t+L+1] = 1;
                                    ec[t+L+1] = 16'(int'(j_cbase) + m * j_n + n);
                                end
                                last_t = t;
                                t++;
                            end
                        end
                    end
            if (!stop && ab > last_t + L + 1) begin
                hi = last_t + L + 1;
                dn[hi+1] = 1;
                t_end[li] = hi + 4;
            end else begin
                hi = ab;
                t_end[li] = ab + 3;
            end
            for (int c = 1; c <= hi; c++) bz[c] = 1;
        end
        for (int c = 0; c < MaxCyc; c++)
            exp_s[li][c] = pack(rd[c], ea[c], eb[c], mv[c], init[c], we[c], ec[c], dn[c], bz[c],
                                !bz[c] && !dn[c]);
    endtask

    task automatic run_job();
        build_model(0);
        build_model(1);
        n_cyc = ((t_end[0] > t_end[1]) ? t_end[0] : t_end[1]) + 1;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            drive(c == 0, stall_mask[c], c == j_ab);
            @(negedge clk);
            obs_s[0][c] = pack(if1.sram_rd_en_o, if1.sram_a_addr_o, if1.sram_b_addr_o,
                               if1.mac_valid_o, if1.mac_init_save_o, if1.sram_c_we_o,
                               if1.sram_c_we_o ? if1.sram_c_addr_o : 16'h0, if1.done_o,
                               if1.busy_o, if1.mac_acc_clr_o);
            obs_s[1][c] = pack(if3.sram_rd_en_o, if3.sram_a_addr_o, if3.sram_b_addr_o,
                               if3.mac_valid_o, if3.mac_init_save_o, if3.sram_c_we_o,
                               if3.sram_c_we_o ? if3.sram_c_addr_o : 16'h0, if3.done_o,
                               if3.busy_o, if3.mac_acc_clr_o);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_job(0, 0, 0, '0, '0, '0, 1'b0, -1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_tests++;
        if ({if1.sram_rd_en_o, if1.sram_a_addr_o, if1.sram_b_addr_o, if1.mac_valid_o,
             if1.mac_init_save_o, if1.mac_acc_clr_o, if1.sram_c_we_o, if1.sram_c_addr_o,
             if1.busy_o, if1.done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs L=1 got nonzero output, required all 0");
        end
        n_tests++;
        if ({if3.sram_rd_en_o, if3.sram_a_addr_o, if3.sram_b_addr_o, if3.mac_valid_o,
             if3.mac_init_save_o, if3.mac_acc_clr_o, if3.sram_c_we_o, if3.sram_c_addr_o,
             if3.busy_o, if3.done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs L=3 got nonzero output, required all 0");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({if1.mac_acc_clr_o, if1.busy_o, if3.mac_acc_clr_o, if3.busy_o} !== 4'b1010) begin
            n_fail++;
            $display("FAIL idle_after_reset got acc/busy=%b required 1010",
                     {if1.mac_acc_clr_o, if1.busy_o, if3.mac_acc_clr_o, if3.busy_o});
        end
    endtask

    task automatic test_single_beat();
        set_job(1, 1, 1, 16'h10, 16'h20, 16'h30, 1'b0, -1);
        run_job();
        for (int li = 0; li < 2; li++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_s[li][c] !== exp_s[li][c]) begin
                    n_fail++;
                    $display("FAIL single L=%0d cyc=%0d got=%h exp=%h", lat_of[li], c,
                             obs_s[li][c], exp_s[li][c]);
                end
            end
        n_tests++;
        if ({obs_s[0][1][54:22], obs_s[0][2][21:20], obs_s[0][3][19:3], obs_s[0][4][2]}
            !== {1'b1, 16'h10, 16'h20, 2'b11, 1'b1, 16'h30, 1'b1}) begin
            n_fail++;
            $display("FAIL single_timing_L1 got rd/a/b=%h mv/init=%b we/c=%h done=%b",
                     obs_s[0][1][54:22], obs_s[0][2][21:20], obs_s[0][3][19:3], obs_s[0][4][2]);
        end
        n_tests++;
        if ({obs_s[1][3][21], obs_s[1][4][21], obs_s[1][5][19], obs_s[1][6][2]} !== 4'b0111) begin
            n_fail++;
            $display("FAIL single_timing_L3 got mv3/mv4/we5/done6=%b required 0111",
                     {obs_s[1][3][21], obs_s[1][4][21], obs_s[1][5][19], obs_s[1][6][2]});
        end
    endtask

    task automatic test_layouts();
        for (int lay = 0; lay < 2; lay++) begin
            set_job(2, 3, 2, 16'h0, 16'h0, 16'h0, 1'(lay), -1);
            run_job();
            for (int li = 0; li < 2; li++)
                for (int c = 0; c < n_cyc; c++) begin
                    n_tests++;
                    if (obs_s[li][c] !== exp_s[li][c]) begin
                        n_fail++;
                        $display("FAIL layout%0d L=%0d cyc=%0d got=%h exp=%h", lay, lat_of[li], c,
                                 obs_s[li][c], exp_s[li][c]);
                    end
                end
        end
    endtask

    task automatic test_stall();
        set_job(2, 3, 2, 16'h0, 16'h0, 16'h0, 1'b0, -1);
        stall_mask[4] = 1'b1;
        stall_mask[5] = 1'b1;
        run_job();
        for (int li = 0; li < 2; li++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_s[li][c] !== exp_s[li][c]) begin
                    n_fail++;
                    $display("FAIL stall L=%0d cyc=%0d got=%h exp=%h", lat_of[li], c,
                             obs_s[li][c], exp_s[li][c]);
                end
            end
        n_tests++;
        if ({obs_s[0][4][54], obs_s[0][5][54], obs_s[0][6][54], obs_s[0][16][2], obs_s[0][17][2]}
            !== 5'b00101) begin
            n_fail++;
            $display("FAIL stall_timing got rd4/rd5/rd6/done16/done17=%b required 00101",
                     {obs_s[0][4][54], obs_s[0][5][54], obs_s[0][6][54], obs_s[0][16][2],
                      obs_s[0][17][2]});
        end
    endtask

    task automatic test_abort();
        set_job(2, 3, 2, 16'h100, 16'h200, 16'h300, 1'b0, 5);
        run_job();
        for (int li = 0; li < 2; li++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_s[li][c] !== exp_s[li][c]) begin
                    n_fail++;
                    $display("FAIL abort L=%0d cyc=%0d got=%h exp=%h", lat_of[li], c,
                             obs_s[li][c], exp_s[li][c]);
                end
            end
        n_tests++;
        if ({obs_s[1][6][1:0], obs_s[1][6][21], obs_s[1][7][21], obs_s[1][7][19], obs_s[1][7][2]}
            !== 6'b010000) begin
            n_fail++;
            $display("FAIL abort_idle_L3 got busy/acc/mv/mv/we/done=%b required 010000",
                     {obs_s[1][6][1:0], obs_s[1][6][21], obs_s[1][7][21], obs_s[1][7][19],
                      obs_s[1][7][2]});
        end
        set_job(1, 2, 2, 16'h40, 16'h50, 16'h60, 1'b1, -1);
        run_job();
        for (int li = 0; li < 2; li++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_s[li][c] !== exp_s[li][c]) begin
                    n_fail++;
                    $display("FAIL after_abort L=%0d cyc=%0d got=%h exp=%h", lat_of[li], c,
                             obs_s[li][c], exp_s[li][c]);
                end
            end
    endtask

    task automatic test_zero_size();
        set_job(2, 0, 2, 16'h10, 16'h20, 16'h30, 1'b0, -1);
        run_job();
        for (int li = 0; li < 2; li++)
            for (int c = 0; c < n_cyc; c++) begin
                n_tests++;
                if (obs_s[li][c] !== exp_s[li][c]) begin
                    n_fail++;
                    $display("FAIL zero_size L=%0d cyc=%0d got=%h exp=%h", lat_of[li], c,
                             obs_s[li][c], exp_s[li][c]);
                end
            end
        n_tests++;
        if ({obs_s[0][1][54], obs_s[0][1][2:1], obs_s[1][1][2:1]} !== 5'b01010) begin
            n_fail++;
            $display("FAIL zero_done got rd/done/busy/done/busy=%b required 01010",
                     {obs_s[0][1][54], obs_s[0][1][2:1], obs_s[1][1][2:1]});
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 14; j++) begin
            set_job(int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
                    int'($urandom_range(4, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom_range(1, 0)),
                    ($urandom_range(3, 0) == 0) ? int'($urandom_range(25, 2)) : -1);
            if ($urandom_range(9, 0) == 0) j_n = 0;
            for (int c = 0; c < MaxCyc; c++) stall_mask[c] = ($urandom_range(3, 0) == 0);
            run_job();
            for (int li = 0; li < 2; li++)
                for (int c = 0; c < n_cyc; c++) begin
                    n_tests++;
                    if (obs_s[li][c] !== exp_s[li][c]) begin
                        n_fail++;
                        $display("FAIL random%0d L=%0d cyc=%0d got=%h exp=%h", j, lat_of[li], c,
                                 obs_s[li][c], exp_s[li][c]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_layouts();
        test_stall();
        test_abort();
        test_zero_size();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
